// File: rtl/pci_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pci_pkg
// Description : Shared encodings for the PCI target sequencer: memory command
//               codes, the sequencer state type and a command classifier.
// Revision    : 1.0 - initial release
// ============================================================================
package pci_pkg;

    localparam logic [3:0] CMD_MEMRD = 4'b0110;
    localparam logic [3:0] CMD_MEMWR = 4'b0111;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BUSY  = 3'd1,
        CLAIM = 3'd2,
        LOCAL = 3'd3,
        XFER  = 3'd4,
        DISC  = 3'd5,
        RETRY = 3'd6,
        TAR   = 3'd7
    } pci_state_t;

    // True for the two commands this target is able to claim
    function automatic logic is_mem_cmd(input logic [3:0] cmd);
        return (cmd == CMD_MEMRD) || (cmd == CMD_MEMWR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pci_par_gen.sv
`default_nettype none
// ============================================================================
// Module      : pci_par_gen
// Description : Registered even-parity generator over AD[31:0] and C/BE#[3:0].
//               The enable is delayed with the data, so the parity bit and its
//               active-low output enable appear together one cycle after en.
// Revision    : 1.0 - initial release
// ============================================================================
module pci_par_gen (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [35:0] data,
    output logic        par,
    output logic        oe_par_n
);

    // Capture parity only when enabled; the enable becomes a one-cycle OE pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par      <= 1'b0;
            oe_par_n <= 1'b1;
        end else begin
            oe_par_n <= ~en;
            if (en) begin
                par <= ^data;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pci_target_seq.sv
`default_nettype none
// ============================================================================
// Module      : pci_target_seq
// Description : PCI target sequencer for single-DWORD memory read/write to one
//               memory BAR. Decodes address phases from registered bus samples,
//               runs a strobe/ack local bus cycle and drives the registered
//               target controls and output enables back to the pad layer.
// Revision    : 1.0 - initial release
// ============================================================================
module pci_target_seq
    import pci_pkg::*;
#(
    parameter int ADDR_BITS = 12,
    parameter int LAT_MAX   = 16
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    FRAME_I_N,
    input  logic                    IRDY_I_N,
    input  logic [31:0]             AD_I,
    input  logic [3:0]              CBE_I_N,
    input  logic [31-ADDR_BITS:0]   BAR0_BASE,
    input  logic                    MEM_EN,
    output logic [31:0]             AD_O,
    output logic                    OE_AD_N,
    output logic                    TRDY_O_N,
    output logic                    DEVSEL_O_N,
    output logic                    STOP_O_N,
    output logic                    OE_TRDY_N,
    output logic                    OE_DEVSEL_N,
    output logic                    OE_STOP_N,
    output logic                    PAR_O,
    output logic                    OE_PAR_N,
    output logic [ADDR_BITS-3:0]    LB_ADDR,
    output logic [31:0]             LB_WDATA,
    output logic [3:0]              LB_BE,
    output logic                    LB_WR,
    output logic                    LB_RD,
    input  logic [31:0]             LB_RDATA,
    input  logic                    LB_ACK
);

    localparam int CNT_W = $clog2(LAT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAT_MAX - 1);

    pci_state_t         state;
    pci_state_t         state_next;
    logic               frame_prev;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_next;
    logic [3:0]         cmd_q;
    logic               is_rd;

    logic               addr_phase;
    logic               hit;
    logic               latch_addr;
    logic               capture_data;
    logic               load_rdata;
    logic               lb_wr_next;
    logic               lb_rd_next;
    logic               trdy_next;
    logic               devsel_next;
    logic               stop_next;
    logic               oe_ctl_next;
    logic               oe_ad_next;
    logic               par_en;

    assign addr_phase = ~FRAME_I_N & frame_prev;
    assign hit        = MEM_EN & is_mem_cmd(CBE_I_N) & (AD_I[31:ADDR_BITS] == BAR0_BASE);
    assign is_rd      = (cmd_q == CMD_MEMRD);
    assign par_en     = (state == XFER) & is_rd;

    // State, latency counter, FRAME# history and latched command
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state      <= IDLE;
            cnt        <= '0;
            frame_prev <= 1'b1;
            cmd_q      <= 4'b0000;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            frame_prev <= FRAME_I_N;
            if (latch_addr) begin
                cmd_q <= CBE_I_N;
            end
        end
    end

    // Next-state decode plus the next values of every registered bus control
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        latch_addr   = 1'b0;
        capture_data = 1'b0;
        load_rdata   = 1'b0;
        lb_wr_next   = 1'b0;
        lb_rd_next   = 1'b0;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (addr_phase) begin
                    latch_addr = 1'b1;
                    state_next = hit ? CLAIM : BUSY;
                end
            end
            BUSY: begin
                if (FRAME_I_N && IRDY_I_N) begin
                    state_next = IDLE;
                end
            end
            CLAIM: begin
                if (cnt < CNT_LAST) begin
                    cnt_next = cnt + CNT_W'(1);
                end
                if (!IRDY_I_N) begin
                    capture_data = 1'b1;
                    lb_wr_next   = ~is_rd;
                    lb_rd_next   = is_rd;
                    state_next   = LOCAL;
                end
            end
            LOCAL: begin
                if (cnt < CNT_LAST) begin
                    cnt_next = cnt + CNT_W'(1);
                end
                // An ack on the threshold cycle still completes the transfer
                if (LB_ACK) begin
                    load_rdata = is_rd;
                    state_next = XFER;
                end else if (cnt >= CNT_LAST) begin
                    state_next = RETRY;
                end
            end
            XFER: begin
                state_next = FRAME_I_N ? TAR : DISC;
            end
            DISC, RETRY: begin
                if (FRAME_I_N) begin
                    state_next = TAR;
                end
            end
            TAR: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being entered
        devsel_next = ~((state_next == CLAIM) || (state_next == LOCAL) ||
                        (state_next == XFER)  || (state_next == DISC)  ||
                        (state_next == RETRY));
        trdy_next   = (state_next != XFER);
        if (state_next == XFER) begin
            stop_next = FRAME_I_N;
        end else if ((state_next == DISC) || (state_next == RETRY)) begin
            stop_next = 1'b0;
        end else begin
            stop_next = 1'b1;
        end
        oe_ctl_next = (state_next == IDLE) || (state_next == BUSY);
        oe_ad_next  = ~(is_rd && ((state_next == XFER) || (state_next == DISC)));
    end

    // Registered target controls, output enables and local-bus outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            TRDY_O_N    <= 1'b1;
            DEVSEL_O_N  <= 1'b1;
            STOP_O_N    <= 1'b1;
            OE_TRDY_N   <= 1'b1;
            OE_DEVSEL_N <= 1'b1;
            OE_STOP_N   <= 1'b1;
            OE_AD_N     <= 1'b1;
            AD_O        <= 32'h0000_0000;
            LB_ADDR     <= '0;
            LB_WDATA    <= 32'h0000_0000;
            LB_BE       <= 4'h0;
            LB_WR       <= 1'b0;
            LB_RD       <= 1'b0;
        end else begin
            TRDY_O_N    <= trdy_next;
            DEVSEL_O_N  <= devsel_next;
            STOP_O_N    <= stop_next;
            OE_TRDY_N   <= oe_ctl_next;
            OE_DEVSEL_N <= oe_ctl_next;
            OE_STOP_N   <= oe_ctl_next;
            OE_AD_N     <= oe_ad_next;
            LB_WR       <= lb_wr_next;
            LB_RD       <= lb_rd_next;
            if (latch_addr) begin
                LB_ADDR <= AD_I[ADDR_BITS-1:2];
            end
            if (capture_data) begin
                LB_WDATA <= AD_I;
                LB_BE    <= ~CBE_I_N;
            end
            if (load_rdata) begin
                AD_O <= LB_RDATA;
            end
        end
    end

    pci_par_gen u_par_gen (
        .clk      (CLK),
        .rst_n    (RST_N),
        .en       (par_en),
        .data     ({AD_O, CBE_I_N}),
        .par      (PAR_O),
        .oe_par_n (OE_PAR_N)
    );

endmodule
`default_nettype wire
